// File: rtl/dpram_fifo_pkg.sv
// rtl/dpram_fifo_pkg.sv - shared geometry for the 128x8 dual-port RAM FIFO
package dpram_fifo_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int CNT_W  = 8;
endpackage

// File: rtl/dpram_128x8.sv
// rtl/dpram_128x8.sv - 128x8 dual-port RAM, one write port and one registered read port
module dpram_128x8
  import dpram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - FIFO controller driving an external dpram_128x8
// Optional sticky ovf/udf error flags enabled by DPRAM_FIFO_CTRL_ERR_EN.
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
#(
  parameter int AFULL_LVL  = 120,
  parameter int AEMPTY_LVL = 8
) (
  input  logic              clk,
  input  logic              RN,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              aempty,
  output logic [CNT_W-1:0]  count,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ovf,
  output logic              udf,
  input  logic              err_clr
);
  localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

  logic [ADDR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0]  count_nxt;
  logic              push_acc, pop_acc;

  // flush takes priority: any request in the flush cycle is dropped
  assign push_acc  = push && !full && !flush;
  assign pop_acc   = pop && !empty && !flush;

  assign ram_wen   = push_acc;
  assign ram_waddr = wptr;
  assign ram_wdata = push_data;
  assign ram_ren   = pop_acc;
  assign ram_raddr = rptr;
  assign pop_data  = ram_rdata;

  always_comb begin
    count_nxt = count;
    if (flush)                 count_nxt = '0;
    else if (push_acc && !pop_acc) count_nxt = count + 1'b1;
    else if (pop_acc && !push_acc) count_nxt = count - 1'b1;
  end

  // flags are registered from count_nxt so they always agree with count
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push_acc) wptr <= wptr + 1'b1;
        if (pop_acc)  rptr <= rptr + 1'b1;
      end
      count     <= count_nxt;
      pop_valid <= pop_acc;
      full      <= (count_nxt == FULL_C);
      empty     <= (count_nxt == '0);
      afull     <= (count_nxt >= AFULL_C);
      aempty    <= (count_nxt <= AEMPTY_C);
    end
  end

`ifdef DPRAM_FIFO_CTRL_ERR_EN
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push && full && !flush) ovf <= 1'b1;
      else if (err_clr)           ovf <= 1'b0;
      if (pop && empty && !flush) udf <= 1'b1;
      else if (err_clr)           udf <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb/tb_dpram_fifo_ctrl.sv - self-checking bench for dpram_fifo_ctrl paired with dpram_128x8
module tb_dpram_fifo_ctrl;
  import dpram_fifo_pkg::*;

`ifdef DPRAM_FIFO_CTRL_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic RN, flush, push, pop, err_clr;
  logic [7:0] push_data;
  logic pop_valid, full, empty, afull, aempty, ovf, udf;
  logic [7:0] pop_data, count;
  logic ram_wen, ram_ren;
  logic [6:0] ram_waddr, ram_raddr;
  logic [7:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.AFULL_LVL(120), .AEMPTY_LVL(8)) dut (
    .clk(clk), .RN(RN), .flush(flush), .push(push), .push_data(push_data),
    .pop(pop), .pop_valid(pop_valid), .pop_data(pop_data),
    .full(full), .empty(empty), .afull(afull), .aempty(aempty), .count(count),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ovf(ovf), .udf(udf), .err_clr(err_clr)
  );

  dpram_128x8 u_ram (
    .clk(clk), .wen(ram_wen), .waddr(ram_waddr), .wdata(ram_wdata),
    .ren(ram_ren), .raddr(ram_raddr), .rdata(ram_rdata)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       push, pop, flush;
    logic [7:0] data;
    logic       x_wen, x_ren;
    logic [7:0] x_count;
    logic       x_empty, x_pv;
    logic [7:0] x_pdata;
  } vec_t;

  vec_t vt [12];

  logic [7:0] mq [$];
  logic [6:0] mw, mr;
  logic       mov, mud;

  task automatic cyc(input logic p, input logic q, input logic [7:0] d);
    logic pa, qa;
    logic [7:0] exp_d;
    exp_d = 8'h00;
    push = p; pop = q; push_data = d;
    #1;
    pa = p && (mq.size() < 128);
    qa = q && (mq.size() > 0);
    chk("cyc_wen", 32'(ram_wen), 32'(pa));
    chk("cyc_ren", 32'(ram_ren), 32'(qa));
    if (pa) chk("cyc_waddr", 32'(ram_waddr), 32'(mw));
    if (pa) chk("cyc_wdata", 32'(ram_wdata), 32'(d));
    if (qa) chk("cyc_raddr", 32'(ram_raddr), 32'(mr));
    if (ERR && p && !pa) mov = 1'b1;
    if (ERR && q && !qa) mud = 1'b1;
    if (qa) begin exp_d = mq.pop_front(); mr = mr + 7'd1; end
    if (pa) begin mq.push_back(d); mw = mw + 7'd1; end
    @(posedge clk); #1;
    chk("cyc_count", 32'(count), 32'(mq.size()));
    chk("cyc_full", 32'(full), 32'(mq.size() == 128));
    chk("cyc_empty", 32'(empty), 32'(mq.size() == 0));
    chk("cyc_afull", 32'(afull), 32'(mq.size() >= 120));
    chk("cyc_aempty", 32'(aempty), 32'(mq.size() <= 8));
    chk("cyc_pop_valid", 32'(pop_valid), 32'(qa));
    if (qa) chk("cyc_pop_data", 32'(pop_data), 32'(exp_d));
    chk("cyc_ovf", 32'(ovf), 32'(mov));
    chk("cyc_udf", 32'(udf), 32'(mud));
    push = 1'b0; pop = 1'b0;
    @(negedge clk);
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_udf", 32'(udf), 32'd0);
    mov = 1'b0; mud = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // push, pop, flush, data, wen, ren, count, empty, pop_valid, pop_data
    vt[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 8'h00};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 8'h00};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 8'h11};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 8'h22};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 8'h33};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'h00};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'h00};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 8'h00};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 8'h44};
    vt[10] = '{1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 8'h00};
    vt[11] = '{1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'h00};

    RN = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(aempty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(afull), 32'd0);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_udf", 32'(udf), 32'd0);
    RN = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      push = vt[i].push; pop = vt[i].pop; flush = vt[i].flush; push_data = vt[i].data;
      #1;
      chk($sformatf("vec%0d_wen", i), 32'(ram_wen), 32'(vt[i].x_wen));
      chk($sformatf("vec%0d_ren", i), 32'(ram_ren), 32'(vt[i].x_ren));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].x_count));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].x_empty));
      chk($sformatf("vec%0d_pop_valid", i), 32'(pop_valid), 32'(vt[i].x_pv));
      if (vt[i].x_pv) chk($sformatf("vec%0d_pop_data", i), 32'(pop_data), 32'(vt[i].x_pdata));
      push = 1'b0; pop = 1'b0; flush = 1'b0;
      @(negedge clk);
    end

    // vector 7 popped while empty
    chk("tbl_udf", 32'(udf), 32'(ERR));
    mq.delete(); mw = 7'd0; mr = 7'd0; mov = 1'b0; mud = 1'b0;
    clr_err();

    for (int i = 0; i < 128; i++) cyc(1'b1, 1'b0, 8'(i));
    cyc(1'b1, 1'b0, 8'hAA);
    clr_err();
    cyc(1'b1, 1'b1, 8'hBB);
    chk("fullpp_count", 32'(count), 32'd127);
    while (mq.size() > 0) cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    clr_err();

    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
    for (int i = 0; i < 130; i++) cyc(1'b1, 1'b1, 8'(i + 3));
    chk("wrap_count", 32'(count), 32'd5);

    // reset lands while the pop response is outstanding
    pop = 1'b1;
    @(posedge clk); #2;
    RN = 1'b0;
    #1;
    chk("midrst_pop_valid", 32'(pop_valid), 32'd0);
    pop = 1'b0;
    @(negedge clk);
    RN = 1'b1;
    @(posedge clk); #1;
    chk("midrst_pv_after", 32'(pop_valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    @(negedge clk);
    mq.delete(); mw = 7'd0; mr = 7'd0; mov = 1'b0; mud = 1'b0;
    cyc(1'b1, 1'b0, 8'h5A);
    cyc(1'b0, 1'b1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dpram_fifo_ctrl.md
DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 SHALL have parameter AFULL_LVL, default 120, almost-full threshold in entries (1..127).
REQ-002 SHALL have parameter AEMPTY_LVL, default 8, almost-empty threshold in entries (1..127).
REQ-003 SHALL have port clk  in  1  single clock for all state; also drives the external dpram_128x8 clk.
REQ-004 SHALL have port RN  in  1  asynchronous active-low reset.
REQ-005 SHALL have port flush  in  1  synchronous clear of pointers, count and pipeline.
REQ-006 SHALL have port push, push_data  in  1, 8  write request and data.
REQ-007 SHALL have port pop  in  1  read request.
REQ-008 SHALL have port pop_valid, pop_data  out  1, 8  read response.
REQ-009 SHALL have port full, empty, afull, aempty  out  1 each  status flags.
REQ-010 SHALL have port count  out  8  occupancy, 0..128.
REQ-011 SHALL have port ram_wen, ram_waddr, ram_wdata  out  1, 7, 8  RAM write port.
REQ-012 SHALL have port ram_ren, ram_raddr  out  1, 7  RAM read port.
REQ-013 SHALL have port ram_rdata  in  8  RAM registered read data.
REQ-014 SHALL have port ovf, udf, err_clr  out, out, in  1 each  sticky error flags and their clear.

Function
REQ-015 SHALL accept a push when push=1 and full=0: ram_wen=1, ram_waddr=wptr, ram_wdata=push_data, all combinational in that cycle; wptr increments at the edge.
REQ-016 SHALL accept a pop when pop=1 and empty=0: ram_ren=1, ram_raddr=rptr combinational; rptr increments at the edge.
REQ-017 SHALL assert pop_valid exactly one cycle after an accepted pop, with pop_data=ram_rdata in that cycle.
REQ-018 SHALL wrap wptr and rptr from 127 to 0.
REQ-019 SHALL update count by +1 (push only), -1 (pop only), or 0 (both or neither accepted).
REQ-020 SHALL reject a push while full, even when a pop is accepted in the same cycle.
REQ-021 SHALL reject a pop while empty, even when a push is accepted in the same cycle.
REQ-022 SHALL drive full=(count==128), empty=(count==0), afull=(count>=AFULL_LVL) and aempty=(count<=AEMPTY_LVL), all registered and consistent with count.
REQ-023 SHALL, on flush, zero wptr, rptr and count, and suppress pop_valid in the next cycle; a push or pop in the flush cycle is ignored.
REQ-024 SHALL drive ram_wen=0 and ram_ren=0 whenever no request is accepted.

Reset
REQ-025 SHALL, while RN=0, hold wptr=0, rptr=0, count=0, pop_valid=0, ovf=0, udf=0, empty=1, aempty=1, full=0 and afull=0.
REQ-026 SHALL, on reset asserted mid-operation, discard the pending pop_valid; no response is produced after RN deasserts.

Configuration
REQ-027 SHALL, with DPRAM_FIFO_CTRL_ERR_EN defined, set ovf on push while full and udf on pop while empty, each held until err_clr=1 or reset; set wins over a simultaneous err_clr.
REQ-028 SHALL, without DPRAM_FIFO_CTRL_ERR_EN, keep ovf, udf and err_clr ports present, tie ovf and udf to 0, and ignore err_clr.

Structure
REQ-029 SHALL take DATA_W=8, ADDR_W=7, DEPTH=128 and CNT_W=8 from shared package dpram_fifo_pkg.
REQ-030 SHALL contain no sub-module; dpram_128x8 is instantiated beside the controller in the enclosing tile wrapper, and the bench uses that pairing.

Verification
REQ-031 SHALL cover: reset, then push 0x11, 0x22, 0x33 and pop 3 times -> pop_data 0x11, 0x22, 0x33, each one cycle after its pop; empty=1 at end.
REQ-032 SHALL cover: 128 pushes of values 0..127 -> full=1, count=128; a 129th push gives ram_wen=0, ovf=1 (ERR_EN defined).
REQ-033 SHALL cover: 130 push/pop pairs at count=5 -> count stays 5, pointers wrap past 127, data order preserved.
REQ-034 SHALL cover: full plus simultaneous push and pop -> pop accepted, push rejected, count=127; empty plus simultaneous push and pop -> push accepted, count=1, no pop_valid.
REQ-035 SHALL cover: RN pulsed low one cycle after a pop -> no pop_valid; count=0, empty=1.
REQ-036 SHALL cover: count 119->120 -> afull rises; count 9->8 -> aempty rises (default parameters).
